// File: rtl/pipe_pkg.sv
// Shared opcode/funct constants, next-PC encodings and control FSM states
// for the pipeline hazard controller and its branch evaluator.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    // cmp_result[1:0] sign/zero classification of rs
    localparam logic [1:0] CMP_GT = 2'b00;
    localparam logic [1:0] CMP_EQ = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    typedef enum logic [2:0] {
        NPC_SEQ = 3'b000,
        NPC_BR  = 3'b001,
        NPC_JMP = 3'b010,
        NPC_JR  = 3'b011,
        NPC_EXC = 3'b100
    } npc_src_t;

    typedef enum logic [1:0] {RUN, LU_STALL, MD_WAIT, EXC} state_t;

    // Opcodes whose rt field is a source operand rather than a destination
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_md_op(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) &&
               ((funct == FN_MULT) || (funct == FN_MULTU) || (funct == FN_DIV) || (funct == FN_DIVU));
    endfunction

    function automatic logic is_mf_op(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID/EX hazard inputs and PC/flush/stall controls of the pipeline controller.
// slave = controller side, master = datapath side.
interface pipe_ctrl_if #(
    parameter int STAGES = 5
);
    logic [31:0]       id_instr;
    logic [2:0]        cmp_result;
    logic              ex_overflow;
    logic              ex_mem_read;
    logic [4:0]        ex_rt;
    logic [2:0]        npc_src;
    logic              stall;
    logic [STAGES-2:0] flush;
    logic              md_busy;
    logic              exc_pending;

    modport master (
        output id_instr, cmp_result, ex_overflow, ex_mem_read, ex_rt,
        input  npc_src, stall, flush, md_busy, exc_pending
    );

    modport slave (
        input  id_instr, cmp_result, ex_overflow, ex_mem_read, ex_rt,
        output npc_src, stall, flush, md_busy, exc_pending
    );
endinterface

// File: rtl/branch_eval.sv
// Branch/jump decode of the ID instruction; purely combinational, zero latency.
// No backpressure: the caller decides whether the decision is honoured.
module branch_eval
    import pipe_pkg::*;
(
    input  logic [31:0] id_instr,
    input  logic [2:0]  cmp_result,
    output logic        taken,
    output npc_src_t    npc_src
);
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;
    logic [1:0] sgn;
    logic       br;
    logic       unused_bits;

    assign op          = id_instr[31:26];
    assign rt          = id_instr[20:16];
    assign funct       = id_instr[5:0];
    assign sgn         = cmp_result[1:0];
    assign unused_bits = ^{id_instr[25:21], id_instr[15:6]};

    always_comb begin
        taken   = 1'b0;
        npc_src = NPC_SEQ;
        br      = 1'b0;
        case (op)
            OP_RTYPE: if ((funct == FN_JR) || (funct == FN_JALR)) begin
                taken   = 1'b1;
                npc_src = NPC_JR;
            end
            OP_J, OP_JAL: begin
                taken   = 1'b1;
                npc_src = NPC_JMP;
            end
            OP_BEQ:  br = cmp_result[2];
            OP_BNE:  br = !cmp_result[2];
            OP_BLEZ: br = (sgn == CMP_EQ) || (sgn == CMP_LT);
            OP_BGTZ: br = (sgn == CMP_GT);
            // rt selects bltz (0) / bgez (1)
            OP_REGIMM: begin
                if (rt == 5'd0)
                    br = (sgn == CMP_LT);
                else if (rt == 5'd1)
                    br = (sgn == CMP_GT) || (sgn == CMP_EQ);
            end
            default: ;
        endcase
        if (br) begin
            taken   = 1'b1;
            npc_src = NPC_BR;
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller (exception > mult/div wait > load-use > branch); outputs same-cycle.
// Stalls hold PC and IF/ID; optional mult/div tracking under PIPE_CTRL_MULDIV_EN.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES   = 5,
    parameter int MD_LAT   = 8,
    parameter int EXC_HOLD = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);
    localparam int FW = STAGES - 1;
    localparam int EW = $clog2(EXC_HOLD + 1);
    localparam logic [EW-1:0] EXC_LOAD = EW'(EXC_HOLD - 1);

    state_t        state;
    logic [EW-1:0] exc_cnt;
    logic [5:0]    op, funct;
    logic [4:0]    rs, rt;
    logic          br_taken;
    npc_src_t      br_npc;
    logic          in_exc, exc_entry, load_use;
    logic          md_hazard, md_hold, md_active;
    npc_src_t      npc;
    logic          stall;
    logic [FW-1:0] flush;
    logic          exc_p;

    assign op    = bus.id_instr[31:26];
    assign rs    = bus.id_instr[25:21];
    assign rt    = bus.id_instr[20:16];
    assign funct = bus.id_instr[5:0];

    branch_eval u_branch_eval (
        .id_instr   (bus.id_instr),
        .cmp_result (bus.cmp_result),
        .taken      (br_taken),
        .npc_src    (br_npc)
    );

    assign in_exc    = (state == EXC);
    assign exc_entry = bus.ex_overflow && !in_exc;
    // In LU_STALL the EX stage holds the bubble we just inserted
    assign load_use  = (state != LU_STALL) && bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                       ((bus.ex_rt == rs) || (reads_rt(op) && (bus.ex_rt == rt)));

`ifdef PIPE_CTRL_MULDIV_EN
    localparam int MW = $clog2(MD_LAT + 1);
    logic [MW-1:0] md_cnt;
    logic          md_issue;

    // md_cnt counts busy cycles remaining after the current one; the issue cycle is busy too
    assign md_hazard = !in_exc && (md_cnt != '0) && (is_md_op(op, funct) || is_mf_op(op, funct));
    assign md_hold   = md_hazard && (md_cnt > MW'(1));
    assign md_issue  = !in_exc && !exc_entry && !md_hazard && !load_use && is_md_op(op, funct);
    assign md_active = md_issue || (md_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            md_cnt <= '0;
        else if (exc_entry)
            md_cnt <= '0;
        else if (md_issue)
            md_cnt <= MW'(MD_LAT - 1);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end
`else
    logic unused_md;
    assign md_hazard = 1'b0;
    assign md_hold   = 1'b0;
    assign md_active = 1'b0;
    assign unused_md = ^{is_md_op(op, funct), is_mf_op(op, funct), MD_LAT[0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            exc_cnt <= '0;
        end else if (exc_entry) begin
            // entry cycle is the first of EXC_HOLD flush cycles
            exc_cnt <= EXC_LOAD;
            state   <= (EXC_LOAD != '0) ? EXC : RUN;
        end else if (in_exc) begin
            exc_cnt <= exc_cnt - 1'b1;
            state   <= (exc_cnt == EW'(1)) ? RUN : EXC;
        end else if (md_hold) begin
            state <= MD_WAIT;
        end else if (load_use && !md_hazard) begin
            state <= LU_STALL;
        end else begin
            state <= RUN;
        end
    end

    always_comb begin
        npc   = NPC_SEQ;
        stall = 1'b0;
        flush = '0;
        exc_p = 1'b0;
        if (rst_n) begin
            if (exc_entry || in_exc) begin
                npc   = exc_entry ? NPC_EXC : NPC_SEQ;
                flush = '1;
                exc_p = 1'b1;
            end else if (md_hazard || load_use) begin
                stall    = 1'b1;
                flush[1] = 1'b1;
            end else if (br_taken) begin
                npc      = br_npc;
                flush[0] = 1'b1;
            end
        end
    end

    assign bus.npc_src     = npc;
    assign bus.stall       = stall;
    assign bus.flush       = flush;
    assign bus.exc_pending = exc_p;
    assign bus.md_busy     = rst_n && md_active;
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 5, number of pipeline stages (legal 5..8); pipeline registers = STAGES-1.
REQ-002 Parameter MD_LAT, default 8, mult/div occupancy in cycles (legal 2..32).
REQ-003 Parameter EXC_HOLD, default 2, cycles the exception flush is held (legal 1..4).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 id_instr  in  32  instruction in ID.
REQ-007 cmp_result  in  3  ID comparator: [2] rs==rt, [1:0] sign/zero of rs (00 >0, 01 =0, 10 <0).
REQ-008 ex_overflow  in  1  arithmetic overflow in EX this cycle.
REQ-009 ex_mem_read  in  1  EX holds a load.
REQ-010 ex_rt  in  5  destination register of the EX load.
REQ-011 npc_src  out  3  next-PC select: 000 seq, 001 branch, 010 j/jal, 011 jr/jalr, 100 exception vector.
REQ-012 stall  out  1  hold PC and IF/ID register.
REQ-013 flush  out  STAGES-1  per-pipeline-register bubble insert; bit0 = IF/ID, bit1 = ID/EX, bit2 = EX/MEM.
REQ-014 md_busy  out  1  mult/div unit occupied.
REQ-015 exc_pending  out  1  exception flush sequence active.

Function
REQ-016 FSM states RUN, LU_STALL, MD_WAIT, EXC; priority EXC > MD_WAIT > LU_STALL > branch/jump.
REQ-017 RUN: branch/jump decode identical to the existing decoder (beq, bne, blez, bgtz, bltz/bgez, j, jal, jr, jalr); taken -> npc_src per REQ-011, flush[0]=1, same cycle, combinational.
REQ-018 Load-use: ex_mem_read=1, ex_rt!=0, and ex_rt equals rs (all opcodes) or rt (opcode 0, beq, bne, sb/sh/sw) -> stall=1, flush[1]=1, npc_src=000, branch decision suppressed; enter LU_STALL for exactly 1 cycle, then RUN.
REQ-019 ex_overflow=1 in any state except EXC -> npc_src=100 that cycle, flush[2:0]=1 for EXC_HOLD cycles (including the entry cycle), exc_pending=1, stall=0; EXC counter counts down, returns to RUN at zero.
REQ-020 ex_overflow while in EXC is ignored; does not restart the counter.
REQ-021 Exception aborts mult/div: md counter cleared, md_busy=0 from the next cycle.
REQ-022 Branch taken and load-use in the same cycle: load-use wins; branch re-evaluated after stall.
REQ-023 Bits of flush above bit2 are constant 0 except during EXC, when all bits below STAGES-1 belong to stages younger than WB and are asserted.

Reset
REQ-024 While rst_n=0: state RUN, all counters 0, npc_src=000, stall=0, flush=0, md_busy=0, exc_pending=0.
REQ-025 Reset mid-sequence (LU_STALL, MD_WAIT, EXC) abandons it immediately; first cycle after release behaves as RUN.

Configuration
REQ-026 Macro PIPE_CTRL_MULDIV_EN defined: mult/multu/div/divu (funct 011000..011011) in ID loads md counter with MD_LAT and asserts md_busy for MD_LAT cycles; mfhi/mflo (010000/010010) or a new mult/div in ID while md_busy -> stall=1, flush[1]=1, state MD_WAIT until counter reaches 0.
REQ-027 Macro undefined: md counter and MD_WAIT absent, md_busy tied 0, those functs produce no stall.

Structure
REQ-028 Shared package pipe_pkg holds opcode/funct constants, npc_src encodings, FSM state enum.
REQ-029 Counter width $clog2(MD_LAT+1); EXC counter width $clog2(EXC_HOLD+1).
REQ-030 One sub-module: branch_eval (combinational taken/npc_src from id_instr and cmp_result).

Verification
REQ-031 beq with cmp_result=3'b100 -> npc_src=001, flush=4'b0001, stall=0 same cycle.
REQ-032 ex_mem_read=1, ex_rt=5, id_instr add with rs=5 -> stall=1, flush[1]=1 for exactly 1 cycle; ex_rt=0 -> no stall.
REQ-033 ex_overflow pulse 1 cycle, EXC_HOLD=2 -> npc_src=100 cycle 0, flush[2:0]=111 cycles 0-1, exc_pending low cycle 2; second overflow in cycle 1 ignored.
REQ-034 MULDIV_EN, MD_LAT=8: mult then mflo next cycle -> stall high 7 cycles, released when md_busy falls.
REQ-035 Overflow during md_busy -> md_busy 0 next cycle, pending mflo stall released.
REQ-036 rst_n low during EXC cycle 1 -> all outputs 0 immediately; after release jal -> npc_src=010.
